// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: ALUControl encodings and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and zero flag from operands and ALUControl code.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SRL: result_o = a_i >> shamt;
      ALU_SLT: result_o[0] = $signed(a_i) < $signed(b_i);
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = a_i << shamt;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single multi-cycle ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             id_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             gnt0, gnt1, in_idle, accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt1 = req1_valid & ~req0_valid;
`else
  // last_q = 1 means port 1 was granted last, so port 0 wins the next tie.
  logic last_q;
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= 1'b1;
    else if (accept) last_q <= gnt1;
  end
`endif

  assign gnt0       = req0_valid & ~gnt1;
  assign in_idle    = (state_q == ST_IDLE) & rst_n;
  assign req0_ready = in_idle & gnt0;
  assign req1_ready = in_idle & gnt1;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) id_q <= gnt1;
      if (state_q == ST_EXEC) begin
        result_q <= core_result;
        zero_q   <= core_zero;
      end
    end
  end

  // Operand capture needs no reset: it is only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= gnt1 ? req1_op : req0_op;
      a_q  <= gnt1 ? req1_a  : req0_a;
      b_q  <= gnt1 ? req1_b  : req0_b;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (core_result),
    .zero_o   (core_zero)
  );

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
